regwrite_arbiter: RTL and testbench
===================================

# regwrite_arbiter

- Sequences and shares the single register-file write port (regwrite / addr_write_reg / write_data) between two writeback requesters:
  - port A: main pipeline writeback;
  - port B: multi-cycle unit (load / mul-div) writeback.
- After reset or a clear request, it zeroes registers 1..31 before it accepts any writeback.
- Outputs are registered on posedge clk, so the negedge-writing register file captures them half a cycle later.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width; register count = 2^ADDR_W
- clk  in  1  system clock; all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  single-cycle pulse; re-runs the zeroing sequence
- a_valid  in  1  port A write request
- a_ready  out  1  port A accepted this cycle (combinational)
- a_addr  in  ADDR_W  port A destination register
- a_data  in  DATA_W  port A write data
- b_valid, b_ready, b_addr, b_data: same as port A, for port B
- regwrite  out  1  register-file write enable (registered)
- addr_write_reg  out  ADDR_W  register-file write address (registered)
- write_data  out  DATA_W  register-file write data (registered)
- init_done  out  1  high while in RUN

## Operation
- **States**
  - INIT: zeroing sequence.
  - RUN: arbitration.
- **Reset values** (rst_n low): state=INIT, init counter=1, last_grant=B, regwrite=0, addr_write_reg=0, write_data=0, init_done=0, a_ready=b_ready=0.
- **INIT**
  - a_ready=b_ready=0 regardless of valids.
  - Each posedge registers regwrite=1, addr_write_reg=counter, write_data=0, then increments the counter.
  - The posedge that registers addr 2^ADDR_W-1 also moves state to RUN.
  - Requests held during INIT are not lost; they are accepted later in RUN.
- **RUN**
  - Grant rules:
    - only A valid: a_ready=1.
    - only B valid: b_ready=1.
    - both valid: grant the port ≠ last_grant; the other port's ready=0.
    - neither valid: no grant.
  - A transfer occurs when valid && ready at a posedge.
  - On a transfer, the next cycle shows regwrite=1 with the granted addr/data, and last_grant becomes the granted port.
  - With no transfer: regwrite=0; addr_write_reg/write_data hold their last values.
  - Address 0:
    - accepted normally (ready asserted, handshake completes);
    - registered regwrite forced to 0, address/data still registered.
    - This keeps r0 hard-zero at the write port.
  - Requesters must hold addr/data stable while valid and not ready.
- **clear**
  - In RUN, clear sampled high at a posedge:
    - takes no transfer that cycle (both readies forced 0 when clear=1);
    - sets counter=1 and state=INIT;
    - regwrite=0 for that cycle, so the sequence starts the following posedge.
  - In INIT, clear restarts the counter at 1.
- **Reset mid-sequence** (rst_n low at any time): immediately returns all state and outputs to reset values. A write in flight on the outputs is dropped; regwrite goes low asynchronously.
- Back-to-back grants to the same address are written in grant order; the arbiter does no merging.

## Timing
- Accept-to-output latency:
  - 1 cycle: posedge N transfer → outputs valid during cycle N+1.
  - Register file writes at the negedge inside cycle N+1.
  - Data is readable combinationally from that negedge on.
- Throughput: one write per cycle. With both ports continuously valid, grants alternate A,B,A,B… Starvation bound is one cycle.
- INIT duration:
  - regwrite high for exactly 2^ADDR_W-1 consecutive cycles (31 at default), starting with the first posedge after rst_n rises.
  - init_done rises in the same cycle the final INIT write is presented.
  - The first RUN transfer can occur at the next posedge.
- Readies are combinational from state, clear and both valids. There is no combinational path from outputs to readies.

## Test plan
- **Zeroing after reset:** release rst_n, no requests.
  - regwrite=1 for 31 cycles, addr 1..31 ascending, data 0.
  - init_done rises with addr 31; then regwrite=0.
- **Single port and latency:** in RUN, A sends addr 5 / data 0xDEADBEEF for one cycle.
  - a_ready=1; next cycle regwrite=1, addr 5, data 0xDEADBEEF.
  - After that negedge, reading r5 returns 0xDEADBEEF.
- **Conflict and round-robin:** A and B both valid continuously (A addr 3 / 0x11, B addr 4 / 0x22) for 4 cycles after reset.
  - Grants A,B,A,B.
  - Output writes are 3/0x11, 4/0x22, 3/0x11, 4/0x22.
  - Exactly one ready high each cycle.
- **Address 0 suppression:** B writes addr 0 / 0xFFFFFFFF.
  - b_ready=1; next cycle regwrite=0; r0 still reads 0.
- **Clear mid-operation:** A valid (addr 7 / 0x7) in the same cycle as clear=1.
  - a_ready=0; no write to r7.
  - The full 31-cycle zeroing sequence follows.
  - After init_done, A's held request is accepted and r7=0x7.
- **Async reset mid-INIT:** drop rst_n at counter=12.
  - regwrite falls immediately; init_done=0.
  - After release, the sequence restarts at addr 1.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// ---------------------------------------------------------------------------
// regwrite_arbiter
//
// Shares the single register-file write port between two writeback
// requesters: port A (main pipeline) and port B (multi-cycle unit).
// After reset or a clear pulse, registers 1..2^ADDR_W-1 are zeroed, one per
// cycle, before any writeback is accepted. The write port outputs are
// registered on posedge clk. The register file writes on the negedge, so it
// captures them half a cycle later.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   clear                      single-cycle pulse, re-runs the zeroing pass
//   a_valid/a_ready/a_addr/a_data   port A request handshake
//   b_valid/b_ready/b_addr/b_data   port B request handshake
//   regwrite, addr_write_reg, write_data   registered write port
//   init_done                  high while arbitrating (RUN)
// ---------------------------------------------------------------------------
module regwrite_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              regwrite,
    output logic [ADDR_W-1:0] addr_write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    // 1 = last grant went to port B. Reset value B makes A win the first tie.
    logic              last_b_q, last_b_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              init_done_q, init_done_d;

    logic              grant_a;
    logic              grant_b;

    // Readies depend only on state, clear and the two valids.
    // On a tie, the port that did not win last time is granted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == ST_RUN && !clear) begin
            if (a_valid && b_valid) begin
                grant_a = last_b_q;
                grant_b = !last_b_q;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_b_d    = last_b_q;
        regwrite_d  = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                if (clear) begin
                    cnt_d = CNT_FIRST;
                end else begin
                    regwrite_d = 1'b1;
                    addr_d     = cnt_q;
                    data_d     = '0;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (clear) begin
                    // No write this cycle; zeroing starts on the next edge.
                    state_d     = ST_INIT;
                    cnt_d       = CNT_FIRST;
                    init_done_d = 1'b0;
                end else if (grant_a) begin
                    // Address 0 still completes the handshake, but r0 is
                    // never written.
                    regwrite_d = |a_addr;
                    addr_d     = a_addr;
                    data_d     = a_data;
                    last_b_d   = 1'b0;
                end else if (grant_b) begin
                    regwrite_d = |b_addr;
                    addr_d     = b_addr;
                    data_d     = b_data;
                    last_b_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = CNT_FIRST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= CNT_FIRST;
            last_b_q    <= 1'b1;
            regwrite_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_b_q    <= last_b_d;
            regwrite_q  <= regwrite_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
        end
    end

    assign regwrite       = regwrite_q;
    assign addr_write_reg = addr_q;
    assign write_data     = data_q;
    assign init_done      = init_done_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regwrite_arbiter
//
// Scenario tasks run in sequence from one initial block. A negedge-writing
// register file is attached to the write port, so written values can be read
// back the way the real pipeline would see them. The random phase compares
// against a request-level model: one pending request per port, tie-break by
// the last winner, and an expected register array.
// ---------------------------------------------------------------------------
module tb_regwrite_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 32;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          regwrite;
    logic [AW-1:0] addr_write_reg;
    logic [DW-1:0] write_data;
    logic          init_done;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] rf [NREG] = '{default: '0};
    logic [DW-1:0] exp_rf [NREG];

    regwrite_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_addr         (a_addr),
        .a_data         (a_data),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .b_addr         (b_addr),
        .b_data         (b_data),
        .regwrite       (regwrite),
        .addr_write_reg (addr_write_reg),
        .write_data     (write_data),
        .init_done      (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: captures the write port on the falling edge.
    always @(negedge clk) begin
        if (regwrite) rf[addr_write_reg] <= write_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reset, then let the 31-cycle zeroing pass finish unchecked.
    task automatic reset_and_init();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NREG - 1) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (regwrite !== 1'b0 || addr_write_reg !== '0 || write_data !== '0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rw=%b addr=%0d data=%h done=%b, required 0/0/0/0",
                     regwrite, addr_write_reg, write_data, init_done);
        end
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_readies: a_ready=%b b_ready=%b, required 0/0", a_ready, b_ready);
        end
        $display("reset: outputs idle");
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_init_sequence();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < NREG; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (regwrite !== 1'b1 || addr_write_reg !== AW'(i) || write_data !== '0) begin
                errors++;
                $display("FAIL init_write: rw=%b addr=%0d data=%h, required 1/%0d/0",
                         regwrite, addr_write_reg, write_data, i);
            end
            checks++;
            if (init_done !== (i == NREG - 1)) begin
                errors++;
                $display("FAIL init_done_timing: init_done=%b at addr %0d, required %b",
                         init_done, i, (i == NREG - 1));
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (regwrite !== 1'b0 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_end: rw=%b done=%b, required 0/1", regwrite, init_done);
        end
        $display("init: zeroing pass of %0d writes observed", NREG - 1);
    endtask

    task automatic test_single();
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = 5'd5;
        a_data  = 32'hDEADBEEF;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: a_ready=%b b_ready=%b, required 1/0", a_ready, b_ready);
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        checks++;
        if (regwrite !== 1'b1 || addr_write_reg !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_write: rw=%b addr=%0d data=%h, required 1/5/deadbeef",
                     regwrite, addr_write_reg, write_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rf[5] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_readback: r5=%h, required deadbeef", rf[5]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (regwrite !== 1'b0 || addr_write_reg !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL idle_hold: rw=%b addr=%0d data=%h, required 0/5/deadbeef",
                     regwrite, addr_write_reg, write_data);
        end
        $display("single: A wrote r5=deadbeef");
    endtask

    task automatic test_addr0();
        @(negedge clk);
        b_valid = 1'b1;
        b_addr  = 5'd0;
        b_data  = 32'hFFFFFFFF;
        #1;
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL addr0_ready: a_ready=%b b_ready=%b, required 0/1", a_ready, b_ready);
        end
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        checks++;
        if (regwrite !== 1'b0 || addr_write_reg !== 5'd0 || write_data !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL addr0_suppress: rw=%b addr=%0d data=%h, required 0/0/ffffffff",
                     regwrite, addr_write_reg, write_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rf[0] !== '0) begin
            errors++;
            $display("FAIL addr0_r0: r0=%h, required 0", rf[0]);
        end
        $display("addr0: B write to r0 suppressed");
    endtask

    task automatic test_round_robin();
        logic exp_a;
        reset_and_init();
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h22;
        exp_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (a_ready !== exp_a || b_ready !== !exp_a) begin
                errors++;
                $display("FAIL rr_grant%0d: a_ready=%b b_ready=%b, required %b/%b",
                         i, a_ready, b_ready, exp_a, !exp_a);
            end
            @(posedge clk);
            #1;
            checks++;
            if (regwrite !== 1'b1 || addr_write_reg !== (exp_a ? 5'd3 : 5'd4) ||
                write_data !== (exp_a ? 32'h11 : 32'h22)) begin
                errors++;
                $display("FAIL rr_write%0d: rw=%b addr=%0d data=%h, required 1/%0d/%h",
                         i, regwrite, addr_write_reg, write_data,
                         exp_a ? 3 : 4, exp_a ? 32'h11 : 32'h22);
            end
            $display("rr: grant %0d to port %s", i, exp_a ? "A" : "B");
            exp_a = !exp_a;
            @(negedge clk);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_clear();
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h7;
        clear   = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: a_ready=%b b_ready=%b, required 0/0", a_ready, b_ready);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        checks++;
        if (regwrite !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL clear_cycle: rw=%b done=%b, required 0/0", regwrite, init_done);
        end
        for (int i = 1; i < NREG; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (regwrite !== 1'b1 || addr_write_reg !== AW'(i) || write_data !== '0 ||
                a_ready !== (i == NREG - 1)) begin
                errors++;
                $display("FAIL clear_init: rw=%b addr=%0d data=%h a_ready=%b, required 1/%0d/0/%b",
                         regwrite, addr_write_reg, write_data, a_ready, i, (i == NREG - 1));
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (regwrite !== 1'b1 || addr_write_reg !== 5'd7 || write_data !== 32'h7) begin
            errors++;
            $display("FAIL clear_held: rw=%b addr=%0d data=%h, required 1/7/7",
                     regwrite, addr_write_reg, write_data);
        end
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        checks++;
        if (rf[7] !== 32'h7) begin
            errors++;
            $display("FAIL clear_readback: r7=%h, required 7", rf[7]);
        end
        $display("clear: re-zeroed, held A request written r7=7");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (addr_write_reg !== 5'd12 || regwrite !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: rw=%b addr=%0d, required 1/12", regwrite, addr_write_reg);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (regwrite !== 1'b0 || init_done !== 1'b0 || addr_write_reg !== '0) begin
            errors++;
            $display("FAIL areset_drop: rw=%b done=%b addr=%0d, required 0/0/0",
                     regwrite, init_done, addr_write_reg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (regwrite !== 1'b1 || addr_write_reg !== AW'(i)) begin
                errors++;
                $display("FAIL areset_restart: rw=%b addr=%0d, required 1/%0d",
                         regwrite, addr_write_reg, i);
            end
        end
        repeat (NREG - 4) @(posedge clk);
        #1;
        $display("areset: sequence restarted at addr 1");
    endtask

    task automatic test_random();
        logic          pa, pb, ga, gb, last_a, exp_rw;
        logic [AW-1:0] pa_addr, pb_addr, m_addr;
        logic [DW-1:0] pa_data, pb_data, m_data;
        reset_and_init();
        for (int r = 0; r < NREG; r++) exp_rf[r] = '0;
        pa = 1'b0; pb = 1'b0;
        pa_addr = '0; pb_addr = '0; pa_data = '0; pb_data = '0;
        last_a = 1'b0;
        m_addr = 5'd31;
        m_data = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!pa) begin
                pa      = ($urandom_range(0, 2) != 0);
                pa_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, NREG - 1));
                pa_data = $urandom;
            end
            if (!pb) begin
                pb      = ($urandom_range(0, 2) != 0);
                pb_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, NREG - 1));
                pb_data = $urandom;
            end
            a_valid = pa; a_addr = pa_addr; a_data = pa_data;
            b_valid = pb; b_addr = pb_addr; b_data = pb_data;
            if (pa && pb) begin
                ga = !last_a;
                gb = last_a;
            end else begin
                ga = pa;
                gb = pb;
            end
            #1;
            checks++;
            if (a_ready !== ga || b_ready !== gb) begin
                errors++;
                $display("FAIL rand_ready c%0d: a_ready=%b b_ready=%b, required %b/%b",
                         c, a_ready, b_ready, ga, gb);
            end
            exp_rw = 1'b0;
            if (ga) begin
                exp_rw = (pa_addr != 0);
                m_addr = pa_addr; m_data = pa_data;
                last_a = 1'b1; pa = 1'b0;
                $display("rand c%0d: A -> r%0d = %h", c, pa_addr, pa_data);
            end else if (gb) begin
                exp_rw = (pb_addr != 0);
                m_addr = pb_addr; m_data = pb_data;
                last_a = 1'b0; pb = 1'b0;
                $display("rand c%0d: B -> r%0d = %h", c, pb_addr, pb_data);
            end
            if (exp_rw) exp_rf[m_addr] = m_data;
            @(posedge clk);
            #1;
            checks++;
            if (regwrite !== exp_rw || addr_write_reg !== m_addr || write_data !== m_data) begin
                errors++;
                $display("FAIL rand_write c%0d: rw=%b addr=%0d data=%h, required %b/%0d/%h",
                         c, regwrite, addr_write_reg, write_data, exp_rw, m_addr, m_data);
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        #1;
        for (int r = 0; r < NREG; r++) begin
            checks++;
            if (rf[r] !== exp_rf[r]) begin
                errors++;
                $display("FAIL rand_regfile r%0d: got %h, required %h", r, rf[r], exp_rf[r]);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        clear   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_addr  = '0;
        b_addr  = '0;
        a_data  = '0;
        b_data  = '0;
        test_reset();
        test_init_sequence();
        test_single();
        test_addr0();
        test_round_robin();
        test_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
